// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration sequencer: writes the per-core cfg register set to every tile, then unfreezes each core.
// Optional BP_CFG_SEQ_TIMEOUT_EN adds an ack-timeout watchdog that drives error_o.
module bp_cfg_sequencer #(
    parameter int cc_x_dim_p        = 2,
    parameter int cc_y_dim_p        = 2,
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 64,
    parameter int max_outstanding_p = 4,
    parameter int timeout_cycles_p  = 1024,
    localparam int num_core_lp      = cc_x_dim_p * cc_y_dim_p,
    localparam int core_w_lp        = (num_core_lp > 1) ? $clog2(num_core_lp) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    input  logic [1:0]                  icache_mode_i,
    input  logic [1:0]                  dcache_mode_i,
    input  logic                        cce_mode_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_w_lp-1:0]        cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ack_v_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o
);

    localparam int cred_w_lp = $clog2(max_outstanding_p + 1);
    localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_lp - 1);
    localparam logic [cred_w_lp-1:0] max_cred_lp  = cred_w_lp'(max_outstanding_p);

    typedef enum logic [2:0] {IDLE, CONFIG, DRAIN0, UNFREEZE, DRAIN1, DONE} state_e;

    state_e                      state_q, state_d;
    logic [core_w_lp-1:0]        core_cnt_q, core_cnt_d;
    logic [2:0]                  reg_idx_q, reg_idx_d;
    logic [cred_w_lp-1:0]        credits_q, credits_d;
    logic [1:0]                  icache_q, icache_d, dcache_q, dcache_d;
    logic                        cce_q, cce_d;
    logic                        cfg_v_q, cfg_v_d;
    logic [core_w_lp-1:0]        cfg_core_q, cfg_core_d;
    logic [cfg_addr_width_p-1:0] cfg_addr_q, cfg_addr_d;
    logic [cfg_data_width_p-1:0] cfg_data_q, cfg_data_d;
    logic                        busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                        xfer, ack_eff;

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    localparam int timer_w_lp = $clog2(timeout_cycles_p + 1);
    localparam logic [timer_w_lp-1:0] timeout_lp = timer_w_lp'(timeout_cycles_p);
    logic [timer_w_lp-1:0] timer_q, timer_d;
`endif

    always_comb begin
        xfer    = cfg_v_q & cfg_ready_i;
        // An ack with nothing outstanding belongs to a write lost to reset; drop it.
        ack_eff = cfg_ack_v_i & (credits_q != '0);

        credits_d = credits_q;
        if (xfer && !ack_eff)      credits_d = credits_q + cred_w_lp'(1);
        else if (!xfer && ack_eff) credits_d = credits_q - cred_w_lp'(1);

        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        reg_idx_d  = reg_idx_q;
        icache_d   = icache_q;
        dcache_d   = dcache_q;
        cce_d      = cce_q;
        done_d     = done_q;
        error_d    = error_q;

        unique case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d    = CONFIG;
                core_cnt_d = '0;
                reg_idx_d  = '0;
                icache_d   = icache_mode_i;
                dcache_d   = dcache_mode_i;
                cce_d      = cce_mode_i;
                done_d     = 1'b0;
                error_d    = 1'b0;
            end
            CONFIG: if (xfer) begin
                if (reg_idx_q == 3'd4) begin
                    reg_idx_d = '0;
                    if (core_cnt_q == last_core_lp) begin
                        state_d    = DRAIN0;
                        core_cnt_d = '0;
                    end else begin
                        core_cnt_d = core_cnt_q + 1'b1;
                    end
                end else begin
                    reg_idx_d = reg_idx_q + 3'd1;
                end
            end
            DRAIN0: if (credits_d == '0) begin
                state_d    = UNFREEZE;
                core_cnt_d = '0;
            end
            UNFREEZE: if (xfer) begin
                if (core_cnt_q == last_core_lp) begin
                    state_d    = DRAIN1;
                    core_cnt_d = '0;
                end else begin
                    core_cnt_d = core_cnt_q + 1'b1;
                end
            end
            DRAIN1: if (credits_d == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

`ifdef BP_CFG_SEQ_TIMEOUT_EN
        timer_d = ((credits_q != '0) && !cfg_ack_v_i) ? timer_q + 1'b1 : '0;
        if (timer_d == timeout_lp) begin
            state_d    = DONE;
            done_d     = 1'b1;
            error_d    = 1'b1;
            credits_d  = '0;
            timer_d    = '0;
            core_cnt_d = '0;
            reg_idx_d  = '0;
        end
`else
        error_d = 1'b0;
`endif

        // Valid holds while the bus stalls; a new write needs a free credit.
        cfg_v_d = ((state_d == CONFIG) || (state_d == UNFREEZE)) &&
                  ((cfg_v_q && !cfg_ready_i) || (credits_d < max_cred_lp));
        busy_d  = (state_d != IDLE) && (state_d != DONE);

        // Payload is a pure function of counters that only move on a transfer, so it is stable under backpressure.
        cfg_core_d = '0;
        cfg_addr_d = '0;
        cfg_data_d = '0;
        if (state_d == CONFIG) begin
            cfg_core_d = core_cnt_d;
            cfg_addr_d = cfg_addr_width_p'({reg_idx_d, 2'b00});
            case (reg_idx_d)
                3'd0:    cfg_data_d = cfg_data_width_p'(1);
                3'd1:    cfg_data_d = cfg_data_width_p'(core_cnt_d);
                3'd2:    cfg_data_d = cfg_data_width_p'(icache_d);
                3'd3:    cfg_data_d = cfg_data_width_p'(dcache_d);
                default: cfg_data_d = cfg_data_width_p'(cce_d);
            endcase
        end else if (state_d == UNFREEZE) begin
            cfg_core_d = core_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            core_cnt_q <= '0;
            reg_idx_q  <= '0;
            credits_q  <= '0;
            icache_q   <= '0;
            dcache_q   <= '0;
            cce_q      <= 1'b0;
            cfg_v_q    <= 1'b0;
            cfg_core_q <= '0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef BP_CFG_SEQ_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            core_cnt_q <= core_cnt_d;
            reg_idx_q  <= reg_idx_d;
            credits_q  <= credits_d;
            icache_q   <= icache_d;
            dcache_q   <= dcache_d;
            cce_q      <= cce_d;
            cfg_v_q    <= cfg_v_d;
            cfg_core_q <= cfg_core_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef BP_CFG_SEQ_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign cfg_v_o    = cfg_v_q;
    assign cfg_core_o = cfg_core_q;
    assign cfg_addr_o = cfg_addr_q;
    assign cfg_data_o = cfg_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Scoreboarded random bench for bp_cfg_sequencer: the expected write stream is queued per start, a negedge monitor checks it.
module tb_bp_cfg_sequencer;

    localparam int NX = 2, NY = 2, N = NX * NY, CW = 2, AW = 16, DW = 64, MO = 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    icache_mode_i = '0, dcache_mode_i = '0;
    logic          cce_mode_i = 1'b0;
    logic          cfg_v_o, cfg_ready_i = 1'b0, cfg_ack_v_i = 1'b0;
    logic [CW-1:0] cfg_core_o;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_data_o;
    logic          busy_o, done_o, error_o;

    always #5 clk_i = ~clk_i;

    bp_cfg_sequencer #(
        .cc_x_dim_p(NX), .cc_y_dim_p(NY), .cfg_addr_width_p(AW), .cfg_data_width_p(DW),
        .max_outstanding_p(MO), .timeout_cycles_p(1024)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
        .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i), .cce_mode_i(cce_mode_i),
        .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_core_o(cfg_core_o),
        .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ack_v_i(cfg_ack_v_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    typedef struct packed {
        logic [CW-1:0] core;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    int  checks = 0, failures = 0;
    int  outst = 0, xfer_cnt = 0;
    int  rmode = 1, amode = 0;   // ready: 0 low, 1 high, 2 random; ack: 0 directed, 1 echo, 2 random
    bit  pend_ack = 0, prev_hold = 0;
    wr_t prev_wr, m_cur, m_exp;
    bit  m_xf, m_ea;

    function automatic wr_t mk(input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.core = c;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: five cfg writes per core in core order, then one unfreeze write per core.
    task automatic push_run(input logic [1:0] ic, input logic [1:0] dc, input logic cc);
        for (int c = 0; c < N; c++) begin
            exp_q.push_back(mk(CW'(c), 16'h0000, 64'd1));
            exp_q.push_back(mk(CW'(c), 16'h0004, DW'(c)));
            exp_q.push_back(mk(CW'(c), 16'h0008, DW'(ic)));
            exp_q.push_back(mk(CW'(c), 16'h000C, DW'(dc)));
            exp_q.push_back(mk(CW'(c), 16'h0010, DW'(cc)));
        end
        for (int c = 0; c < N; c++) exp_q.push_back(mk(CW'(c), 16'h0000, 64'd0));
    endtask

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            outst     = 0;
            prev_hold = 0;
            pend_ack  = 0;
        end else begin
            m_cur = mk(cfg_core_o, cfg_addr_o, cfg_data_o);
            m_xf  = cfg_v_o && cfg_ready_i;
            if (cfg_v_o) chk("valid_within_credits", 64'(outst < MO), 64'd1);
            if (prev_hold) begin
                chk("hold_valid", 64'(cfg_v_o), 64'd1);
                chk("hold_payload", 64'(m_cur == prev_wr), 64'd1);
            end
            if (done_o) chk("done_implies_not_busy", 64'(busy_o), 64'd0);
            if (m_xf) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got core %0d addr %0h data %0h expected none",
                             cfg_core_o, cfg_addr_o, cfg_data_o);
                end else begin
                    m_exp = exp_q.pop_front();
                    chk("wr_core", 64'(m_cur.core), 64'(m_exp.core));
                    chk("wr_addr", 64'(m_cur.addr), 64'(m_exp.addr));
                    chk("wr_data", m_cur.data, m_exp.data);
                end
                log_q.push_back(m_cur);
                xfer_cnt++;
            end
            m_ea      = cfg_ack_v_i && (outst > 0);
            outst     = outst + int'(m_xf) - int'(m_ea);
            prev_hold = cfg_v_o && !cfg_ready_i;
            prev_wr   = m_cur;
            pend_ack  = m_xf;
        end
    end

    task automatic step(input bit st = 1'b0, input bit fa = 1'b0);
        @(posedge clk_i);
        #1;
        start_i = st;
        case (rmode)
            0:       cfg_ready_i = 1'b0;
            1:       cfg_ready_i = 1'b1;
            default: cfg_ready_i = ($urandom_range(0, 3) != 0);
        endcase
        case (amode)
            0:       cfg_ack_v_i = fa;
            1:       cfg_ack_v_i = pend_ack;
            default: cfg_ack_v_i = (outst > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        endcase
    endtask

    task automatic finish_run(input string nm, input int base);
        int n = 0;
        step();
        while (!done_o && n < 2000) begin
            step();
            n++;
        end
        if (!done_o) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout: got done_o 0 expected 1", nm);
        end
        chk({nm, "_busy"}, 64'(busy_o), 64'd0);
        chk({nm, "_error"}, 64'(error_o), 64'd0);
        chk({nm, "_valid_idle"}, 64'(cfg_v_o), 64'd0);
        chk({nm, "_write_count"}, 64'(xfer_cnt - base), 64'(6 * N));
        chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic random_modes();
        icache_mode_i = 2'($urandom);
        dcache_mode_i = 2'($urandom);
        cce_mode_i    = 1'($urandom);
    endtask

    initial begin
        int base, n;
        int ea[5] = '{0, 4, 8, 12, 16};
        int ed[5] = '{1, 2, 2, 1, 1};

        #2 reset_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(cfg_v_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_addr", 64'(cfg_addr_o), 64'd0);
        chk("rst_data", cfg_data_o, 64'd0);
        reset_n_i = 1'b1;

        // Baseline: always ready, ack one cycle after each transfer
        rmode = 1; amode = 1;
        icache_mode_i = 2'd2; dcache_mode_i = 2'd1; cce_mode_i = 1'b1;
        base = xfer_cnt;
        push_run(2'd2, 2'd1, 1'b1);
        step(1'b1);
        finish_run("baseline", base);
        if (log_q.size() >= base + 6 * N) begin
            for (int i = 0; i < 5; i++) begin
                chk("core2_core", 64'(log_q[base + 10 + i].core), 64'd2);
                chk("core2_addr", 64'(log_q[base + 10 + i].addr), 64'(ea[i]));
                chk("core2_data", log_q[base + 10 + i].data, 64'(ed[i]));
            end
            for (int c = 0; c < N; c++) begin
                chk("unfreeze_core", 64'(log_q[base + 5 * N + c].core), 64'(c));
                chk("unfreeze_data", log_q[base + 5 * N + c].data, 64'd0);
            end
        end

        // Spurious acks with nothing outstanding, then the credit limit
        amode = 0;
        repeat (3) step(1'b0, 1'b1);
        step();
        rmode = 1;
        random_modes();
        base = xfer_cnt;
        push_run(icache_mode_i, dcache_mode_i, cce_mode_i);
        step(1'b1);
        repeat (20) step();
        chk("credit_limit_count", 64'(xfer_cnt - base), 64'(MO));
        chk("credit_limit_valid", 64'(cfg_v_o), 64'd0);
        step(1'b0, 1'b1);
        repeat (10) step();
        chk("one_ack_one_write", 64'(xfer_cnt - base), 64'(MO + 1));
        chk("one_ack_valid", 64'(cfg_v_o), 64'd0);
        rmode = 2; amode = 2;
        finish_run("credit_limit", base);

        // Ack coincident with a transfer at two outstanding
        rmode = 1; amode = 0;
        random_modes();
        base = xfer_cnt;
        push_run(icache_mode_i, dcache_mode_i, cce_mode_i);
        step(1'b1);
        n = 0;
        while ((xfer_cnt - base) < 2 && n < 50) begin
            step();
            n++;
        end
        chk("reach_two_outstanding", 64'(xfer_cnt - base), 64'd2);
        step(1'b0, 1'b1);
        repeat (20) step();
        chk("simul_ack_count", 64'(xfer_cnt - base), 64'(MO + 1));
        rmode = 2; amode = 2;
        finish_run("simul_ack", base);

        // Backpressure: payload frozen while ready is low
        rmode = 0; amode = 2;
        random_modes();
        base = xfer_cnt;
        push_run(icache_mode_i, dcache_mode_i, cce_mode_i);
        step(1'b1);
        n = 0;
        while (!cfg_v_o && n < 20) begin
            step();
            n++;
        end
        chk("bp_valid_seen", 64'(cfg_v_o), 64'd1);
        begin
            wr_t held;
            held = mk(cfg_core_o, cfg_addr_o, cfg_data_o);
            for (int i = 0; i < 5; i++) begin
                step();
                chk("bp_valid", 64'(cfg_v_o), 64'd1);
                chk("bp_core", 64'(cfg_core_o), 64'(held.core));
                chk("bp_addr", 64'(cfg_addr_o), 64'(held.addr));
                chk("bp_data", cfg_data_o, held.data);
            end
        end
        chk("bp_no_write", 64'(xfer_cnt - base), 64'd0);
        rmode = 1;
        step();
        rmode = 0;
        repeat (3) step();
        chk("bp_one_write", 64'(xfer_cnt - base), 64'd1);
        rmode = 2;
        finish_run("backpressure", base);

        // Reset at core 1, idx3, then restart from core 0
        rmode = 2; amode = 2;
        random_modes();
        base = xfer_cnt;
        push_run(icache_mode_i, dcache_mode_i, cce_mode_i);
        step(1'b1);
        n = 0;
        while ((xfer_cnt - base) < 8 && n < 200) begin
            step();
            n++;
        end
        chk("reach_core1_idx3", 64'(xfer_cnt - base), 64'd8);
        reset_n_i = 1'b0;
        #1;
        chk("midrst_valid", 64'(cfg_v_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_core", 64'(cfg_core_o), 64'd0);
        chk("midrst_addr", 64'(cfg_addr_o), 64'd0);
        chk("midrst_data", cfg_data_o, 64'd0);
        exp_q.delete();
        step();
        step();
        reset_n_i = 1'b1;
        random_modes();
        base = xfer_cnt;
        push_run(icache_mode_i, dcache_mode_i, cce_mode_i);
        step(1'b1);
        finish_run("restart", base);

        // Random runs; modes change and start re-pulses mid-run, both must be ignored
        for (int r = 0; r < 6; r++) begin
            rmode = 2; amode = 2;
            random_modes();
            base = xfer_cnt;
            push_run(icache_mode_i, dcache_mode_i, cce_mode_i);
            step(1'b1);
            repeat ($urandom_range(3, 15)) step();
            random_modes();
            step(1'b1);
            finish_run("random", base);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_cfg_sequencer.md
Name: bp_cfg_sequencer

Overview:
- Boot-time configuration controller for a multicore processor instance.
- On a start pulse, walks every core tile (cc_x_dim × cc_y_dim) and issues a fixed sequence of configuration-register writes over a shared valid/ready cfg bus, then releases each core from freeze.
- Sits between the host/boot logic and the tile cfg networks.
- Bounds outstanding writes with a credit counter and reports done/busy.

Parameters:
- cc_x_dim_p, 2, core columns
- cc_y_dim_p, 2, core rows; num_core = cc_x_dim_p*cc_y_dim_p
- cfg_addr_width_p, 16, cfg register address width
- cfg_data_width_p, 64, cfg write data width
- max_outstanding_p, 4, maximum unacknowledged writes (≥1)
- timeout_cycles_p, 1024, ack timeout (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begin sequence (ignored unless IDLE or DONE)
- icache_mode_i  in  2  value written to every core's icache-mode register
- dcache_mode_i  in  2  value written to every core's dcache-mode register
- cce_mode_i  in  1  value written to every core's CCE-mode register
- cfg_v_o  out  1  write valid
- cfg_ready_i  in  1  bus ready; transfer when cfg_v_o & cfg_ready_i
- cfg_core_o  out  clog2(num_core)  destination core id
- cfg_addr_o  out  cfg_addr_width_p  register address
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended
- cfg_ack_v_i  in  1  one write acknowledged (any core)
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence complete, held until next start_i
- error_o  out  1  ack timeout (optional feature only; otherwise constant 0)

Behaviour:
- Reset (async, reset_n_i=0): state IDLE; core_cnt=0; reg_idx=0; credits=0; all outputs 0.
- Register map, fixed per-core order in CONFIG phase:
  - idx0: addr 0x0000 freeze, data 1
  - idx1: addr 0x0004 core_id, data core_cnt
  - idx2: addr 0x0008 icache_mode_i
  - idx3: addr 0x000C dcache_mode_i
  - idx4: addr 0x0010 cce_mode_i
- Mode inputs are sampled when start_i is accepted; later changes do not affect the run.
- States:
  - IDLE: start_i → CONFIG.
  - CONFIG: issue idx0..4 for core 0, then core 1, …, core num_core-1. After the last transfer (core num_core-1, idx4) → DRAIN0.
  - DRAIN0: wait credits==0 → UNFREEZE, core_cnt=0.
  - UNFREEZE: one write per core, addr 0x0000, data 0, core order 0..num_core-1. After the last transfer → DRAIN1.
  - DRAIN1: credits==0 → DONE.
  - DONE: done_o=1; start_i → CONFIG (clears done_o the next cycle).
- cfg_v_o is high in CONFIG/UNFREEZE only when credits < max_outstanding_p.
- Once asserted, cfg_v_o, core, addr and data stay stable until the transfer completes; this holds even when an ack arrives.
- Counters advance only on a transfer: reg_idx wraps 4→0 and increments core_cnt.
- Credits:
  - +1 on transfer, -1 on cfg_ack_v_i.
  - Simultaneous transfer and ack leaves credits unchanged.
  - An ack at credits==0 is ignored (no underflow).
  - Credits are never above max_outstanding_p.
- busy_o = state ∉ {IDLE, DONE}. start_i while busy is ignored.
- Single-core config (num_core=1): cfg_core_o is 1 bit wide and always 0.
- Total writes per run: 6×num_core.
- Reset mid-sequence returns to IDLE immediately. In-flight acks arriving after reset are ignored because credits=0.

Optional Feature:
- Macro: BP_CFG_SEQ_TIMEOUT_EN.
- Enabled:
  - A timer counts cycles while credits>0 with no ack, and clears on any ack or when credits==0.
  - When the timer reaches timeout_cycles_p: error_o=1 (sticky), state → DONE with done_o=1, credits cleared.
  - error_o clears on the next accepted start_i or on reset.
- Disabled: no timer; error_o tied to 0; DRAIN states wait indefinitely.

Test Plan:
- Baseline 2×2 run:
  - Stimulus: cfg_ready_i=1, ack one cycle after each transfer, icache=2, dcache=1, cce=1.
  - Response: 24 transfers in order. Core 2 gets (0x0000,1), (0x0004,2), (0x0008,2), (0x000C,1), (0x0010,1). Then unfreeze writes data 0 to cores 0..3. done_o rises after the final ack; busy_o falls in the same cycle.
- Credit limit:
  - Stimulus: max_outstanding_p=4, no acks.
  - Response: exactly 4 transfers, then cfg_v_o=0 and the bus holds. A single ack lets exactly one more transfer through.
- Backpressure stability:
  - Stimulus: cfg_ready_i low for 5 cycles while cfg_v_o=1.
  - Response: addr, data and core are unchanged across all 5 cycles, and exactly one transfer is counted.
- Simultaneous transfer and ack at credits==2:
  - Response: credits stays 2.
  - Also: a spurious ack at credits==0 leaves credits at 0.
- Reset mid-CONFIG and restart:
  - Stimulus: assert reset_n_i=0 at core 1, idx3.
  - Response: all outputs 0 immediately. A subsequent start_i restarts from core 0, idx0.
- Timeout (BP_CFG_SEQ_TIMEOUT_EN, timeout_cycles_p=16):
  - Stimulus: acks withheld.
  - Response: error_o=1 and done_o=1 16 cycles after the last ack-free credit cycle began. The next start_i clears error_o.
